// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: FIFO of register write-backs drained one per cycle into the register file.
// Define REGFILE_WBQ_FORWARD_EN to enable youngest-pending-value forwarding on lk_reg.
module regfile_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [4:0]    req_reg,
    input  logic [31:0]   req_data,
    input  logic          drain_en,
    output logic          reg_write,
    output logic [4:0]    wr,
    output logic [31:0]   data_in,
    output logic [AW:0]   count,
    input  logic [4:0]    lk_reg,
    output logic          lk_hit,
    output logic [31:0]   lk_data
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [4:0]       reg_q  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [AW-1:0]    head, tail;
    logic             push, pop;

    assign req_ready = count != FULL;
    // Writes to r0 complete the handshake but are dropped here.
    assign push      = req_valid && req_ready && req_reg != 5'd0;
    assign reg_write = drain_en && count != '0;
    assign pop       = reg_write;
    assign wr        = count != '0 ? reg_q[head] : 5'd0;
    assign data_in   = count != '0 ? data_q[head] : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (push) begin
                tail        <= tail + 1'b1;
                valid[tail] <= 1'b1;
            end
            if (pop) begin
                head        <= head + 1'b1;
                valid[head] <= 1'b0;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            reg_q[tail]  <= req_reg;
            data_q[tail] <= req_data;
        end
    end

`ifdef REGFILE_WBQ_FORWARD_EN
    // Walk oldest to youngest so the last match is the youngest.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[head + AW'(i)] && lk_reg != 5'd0 && reg_q[head + AW'(i)] == lk_reg) begin
                lk_hit  = 1'b1;
                lk_data = data_q[head + AW'(i)];
            end
        end
    end
`else
    logic unused_lk;
    assign unused_lk = ^{lk_reg, valid};
    assign lk_hit    = 1'b0;
    assign lk_data   = 32'd0;
`endif
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue: directed plus random stimulus checked against a queue model every cycle.
module tb_regfile_writeback_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 0, rst = 1, req_valid = 0, drain_en = 0;
    logic [4:0]  req_reg = 0, lk_reg = 0;
    logic [31:0] req_data = 0;
    logic        req_ready, reg_write, lk_hit;
    logic [4:0]  wr;
    logic [31:0] data_in, lk_data;
    logic [AW:0] count;

    regfile_writeback_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_reg(req_reg), .req_data(req_data), .drain_en(drain_en),
        .reg_write(reg_write), .wr(wr), .data_in(data_in), .count(count),
        .lk_reg(lk_reg), .lk_hit(lk_hit), .lk_data(lk_data)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    logic [4:0]  mr[$];
    logic [31:0] md[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending writes as a queue, front is next to be written.
    always @(negedge clk) begin
        int n;
        logic eh, rdy;
        logic [31:0] ed;
        if (rst) begin
            mr.delete();
            md.delete();
        end
        n  = mr.size();
        eh = 0;
        ed = 0;
`ifdef REGFILE_WBQ_FORWARD_EN
        if (lk_reg != 0)
            foreach (mr[i]) if (mr[i] == lk_reg) begin eh = 1; ed = md[i]; end
`endif
        chk("m_count", 32'(count), 32'(n));
        chk("m_req_ready", 32'(req_ready), 32'(n != DEPTH));
        chk("m_reg_write", 32'(reg_write), 32'(drain_en && n > 0));
        chk("m_wr", 32'(wr), n > 0 ? 32'(mr[0]) : 32'd0);
        chk("m_data_in", data_in, n > 0 ? md[0] : 32'd0);
        chk("m_lk_hit", 32'(lk_hit), 32'(eh));
        chk("m_lk_data", lk_data, ed);
        if (!rst) begin
            rdy = n != DEPTH;
            if (drain_en && n > 0) begin
                void'(mr.pop_front());
                void'(md.pop_front());
            end
            if (req_valid && rdy && req_reg != 0) begin
                mr.push_back(req_reg);
                md.push_back(req_data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(logic v, logic [4:0] r, logic [31:0] d);
        req_valid = v;
        req_reg   = r;
        req_data  = d;
    endtask

    initial begin
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_reg_write", 32'(reg_write), 0);
        chk("rst_lk_hit", 32'(lk_hit), 0);
        cyc();
        rst = 0;
        cyc();

        // single write
        drain_en = 1;
        req(1, 5, 32'hDEADBEEF);
        cyc();
        req(0, 0, 0);
        #1;
        chk("single_reg_write", 32'(reg_write), 1);
        chk("single_wr", 32'(wr), 5);
        chk("single_data", data_in, 32'hDEADBEEF);
        cyc();
        chk("single_count", 32'(count), 0);

        // fill and overflow
        drain_en = 0;
        for (int i = 0; i < 4; i++) begin
            req(1, 5'(i + 1), 32'hA0 + i);
            cyc();
        end
        req(0, 0, 0);
        #1;
        chk("full_count", 32'(count), 4);
        chk("full_ready", 32'(req_ready), 0);
        req(1, 9, 32'h99);
        cyc();
        req(0, 0, 0);
        #1;
        chk("ovf_count", 32'(count), 4);
        drain_en = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_we", 32'(reg_write), 1);
            chk("drain_wr", 32'(wr), 32'(i + 1));
            chk("drain_data", data_in, 32'hA0 + i);
            cyc();
        end
        #1;
        chk("drain_done", 32'(reg_write), 0);

        // forwarding
        drain_en = 0;
        req(1, 7, 32'h11);
        cyc();
        req(1, 7, 32'h22);
        cyc();
        req(0, 0, 0);
        lk_reg = 7;
        #1;
`ifdef REGFILE_WBQ_FORWARD_EN
        chk("fwd_hit", 32'(lk_hit), 1);
        chk("fwd_data", lk_data, 32'h22);
`else
        chk("fwd_hit_off", 32'(lk_hit), 0);
        chk("fwd_data_off", lk_data, 0);
`endif
        lk_reg = 3;
        #1;
        chk("fwd_miss", 32'(lk_hit), 0);
        drain_en = 1;
        cyc();
        cyc();
        #1;
        chk("fwd_drained", 32'(count), 0);

        // register 0 dropped
        drain_en = 1;
        req(1, 0, 32'h1234);
        #1;
        chk("r0_ready", 32'(req_ready), 1);
        cyc();
        req(0, 0, 0);
        #1;
        chk("r0_count", 32'(count), 0);
        chk("r0_reg_write", 32'(reg_write), 0);

        // simultaneous push/pop across pointer wrap
        drain_en = 0;
        req(1, 10, 32'h100);
        cyc();
        req(1, 11, 32'h101);
        cyc();
        drain_en = 1;
        for (int i = 0; i < 10; i++) begin
            req(1, 5'(12 + i), 32'h200 + i);
            cyc();
            chk("pp_count", 32'(count), 2);
        end
        req(0, 0, 0);
        cyc();
        cyc();
        cyc();

        // random
        for (int i = 0; i < 600; i++) begin
            req($urandom % 4 != 0, 5'($urandom % 32), $urandom);
            drain_en = (i / 100) % 2 == 0 ? ($urandom % 3 != 0) : ($urandom % 4 == 0);
            lk_reg   = 5'($urandom % 8);
            cyc();
        end

        // reset mid-operation
        req(0, 0, 0);
        drain_en = 1;
        cyc();
        cyc();
        cyc();
        cyc();
        cyc();
        drain_en = 0;
        for (int i = 0; i < 3; i++) begin
            req(1, 5'(20 + i), 32'h300 + i);
            cyc();
        end
        req(0, 0, 0);
        #1;
        chk("pre_rst_count", 32'(count), 3);
        #1;
        rst = 1;
        drain_en = 1;
        #1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_we", 32'(reg_write), 0);
        chk("mid_rst_ready", 32'(req_ready), 1);
        cyc();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_rst_we", 32'(reg_write), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
